// File: rtl/decode_queue_if.sv
// Fetch-side and execute-side handshake bundle for decode_queue.
// The slave modport is the queue itself; the master modport is its surroundings.
interface decode_queue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [31:0] out_imm;
  logic [2:0]  out_class;
  logic [2:0]  out_funct3;
  logic        out_alt;
  logic        out_muldiv;
  logic        out_link;
  logic        out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm,
           out_class, out_funct3, out_alt, out_muldiv, out_link, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm,
           out_class, out_funct3, out_alt, out_muldiv, out_link, out_illegal
  );
endinterface

// File: rtl/decode_queue.sv
// Instruction FIFO between fetch and execute; the head is decoded combinationally
// and captured into a registered bundle stage with its own valid/ready handshake.
module decode_queue #(
  parameter int DEPTH    = 4,
  parameter int ENABLE_M = 1,
  parameter int ENABLE_F = 0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  decode_queue_if.slave            bus,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

  logic [31:0]   r_mem_instr [DEPTH];
  logic [31:0]   r_mem_pc    [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic        r_out_valid;
  logic [31:0] r_pc;
  logic [4:0]  r_rd;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [31:0] r_imm;
  logic [2:0]  r_class;
  logic [2:0]  r_funct3;
  logic        r_alt;
  logic        r_muldiv;
  logic        r_link;
  logic        r_illegal;

  logic        w_in_ready;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_i;
  logic [31:0] w_head_pc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  fmt_e        w_fmt;
  logic [2:0]  w_class;
  logic        w_alt;
  logic        w_muldiv;
  logic        w_link;
  logic        w_illegal;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [31:0] w_imm;

  // Ready depends only on occupancy, so a pop never opens room in the same cycle.
  assign w_in_ready = (r_count != FULL_CNT);
  assign w_push     = bus.in_valid && w_in_ready && !flush;
  assign w_pop      = (r_count != '0) && (!r_out_valid || bus.out_ready);

  assign w_i       = r_mem_instr[r_rd_ptr];
  assign w_head_pc = r_mem_pc[r_rd_ptr];
  assign w_f3      = w_i[14:12];
  assign w_f7      = w_i[31:25];

  always_comb begin
    w_fmt     = FMT_R;
    w_class   = 3'd0;
    w_alt     = 1'b0;
    w_muldiv  = 1'b0;
    w_link    = 1'b0;
    w_illegal = 1'b0;
    case (w_i[6:0])
      7'b0110011: begin
        w_fmt = FMT_R;
        w_alt = w_i[30];
        case (w_f7)
          7'b0000000: ;
          7'b0100000: w_illegal = !(w_f3 == 3'b000 || w_f3 == 3'b101);
          7'b0000001: begin
            w_muldiv  = (ENABLE_M != 0);
            w_illegal = (ENABLE_M == 0);
          end
          default: w_illegal = 1'b1;
        endcase
      end
      7'b0010011: begin
        w_fmt   = FMT_I;
        w_class = 3'd1;
        if (w_f3 == 3'b001)
          w_illegal = (w_f7 != 7'b0000000);
        if (w_f3 == 3'b101) begin
          w_alt     = w_i[30];
          w_illegal = !(w_f7 == 7'b0000000 || w_f7 == 7'b0100000);
        end
      end
      7'b0000011: begin
        w_fmt     = FMT_I;
        w_class   = 3'd2;
        w_illegal = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
      end
      7'b0100011: begin
        w_fmt     = FMT_S;
        w_class   = 3'd3;
        w_illegal = (w_f3 > 3'b010);
      end
      7'b1100011: begin
        w_fmt     = FMT_B;
        w_class   = 3'd4;
        w_illegal = (w_f3 == 3'b010) || (w_f3 == 3'b011);
      end
      7'b1101111: begin w_fmt = FMT_J; w_class = 3'd5; end
      7'b1100111: begin w_fmt = FMT_I; w_class = 3'd5; w_link = 1'b1; end
      7'b0110111: begin w_fmt = FMT_U; w_class = 3'd6; end
      7'b0010111: begin w_fmt = FMT_U; w_class = 3'd6; w_link = 1'b1; end
      7'b0001111,
      7'b1110011: begin w_fmt = FMT_I; w_class = 3'd7; end
      // FP encodings reuse the integer load/store/register classes.
      7'b0000111: begin w_fmt = FMT_I; w_class = 3'd2; w_illegal = (ENABLE_F == 0); end
      7'b0100111: begin w_fmt = FMT_S; w_class = 3'd3; w_illegal = (ENABLE_F == 0); end
      7'b1010011: begin w_fmt = FMT_R; w_class = 3'd0; w_illegal = (ENABLE_F == 0); end
      default:    w_illegal = 1'b1;
    endcase
    if (w_i[1:0] != 2'b11)
      w_illegal = 1'b1;
  end

  always_comb begin
    w_rd  = '0;
    w_rs1 = '0;
    w_rs2 = '0;
    w_imm = '0;
    if ((w_fmt == FMT_R || w_fmt == FMT_I || w_fmt == FMT_U || w_fmt == FMT_J) && !w_illegal)
      w_rd = w_i[11:7];
    if (w_fmt == FMT_R || w_fmt == FMT_I || w_fmt == FMT_S || w_fmt == FMT_B)
      w_rs1 = w_i[19:15];
    if (w_fmt == FMT_R || w_fmt == FMT_S || w_fmt == FMT_B)
      w_rs2 = w_i[24:20];
    case (w_fmt)
      FMT_I:   w_imm = {{20{w_i[31]}}, w_i[31:20]};
      FMT_S:   w_imm = {{20{w_i[31]}}, w_i[31:25], w_i[11:7]};
      FMT_B:   w_imm = {{19{w_i[31]}}, w_i[31], w_i[7], w_i[30:25], w_i[11:8], 1'b0};
      FMT_U:   w_imm = {w_i[31:12], 12'b0};
      FMT_J:   w_imm = {{11{w_i[31]}}, w_i[31], w_i[19:12], w_i[20], w_i[30:21], 1'b0};
      default: w_imm = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_instr[r_wr_ptr] <= bus.in_instr;
      r_mem_pc[r_wr_ptr]    <= bus.in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_pc        <= '0;
      r_rd        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_imm       <= '0;
      r_class     <= '0;
      r_funct3    <= '0;
      r_alt       <= 1'b0;
      r_muldiv    <= 1'b0;
      r_link      <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
      if (w_pop) begin
        r_out_valid <= 1'b1;
        r_pc        <= w_head_pc;
        r_rd        <= w_rd;
        r_rs1       <= w_rs1;
        r_rs2       <= w_rs2;
        r_imm       <= w_imm;
        r_class     <= w_class;
        r_funct3    <= w_f3;
        r_alt       <= w_alt;
        r_muldiv    <= w_muldiv;
        r_link      <= w_link;
        r_illegal   <= w_illegal;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_pc      = r_pc;
  assign bus.out_rd      = r_rd;
  assign bus.out_rs1     = r_rs1;
  assign bus.out_rs2     = r_rs2;
  assign bus.out_imm     = r_imm;
  assign bus.out_class   = r_class;
  assign bus.out_funct3  = r_funct3;
  assign bus.out_alt     = r_alt;
  assign bus.out_muldiv  = r_muldiv;
  assign bus.out_link    = r_link;
  assign bus.out_illegal = r_illegal;
  assign count           = r_count;
endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: a queue-based flow model plus a rule-table decoder drive
// the expectations; a second instance covers ENABLE_M = 0 / ENABLE_F = 1.
module tb_decode_queue;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] count;
  logic [2:0] count_nm;

  decode_queue_if bus ();
  decode_queue_if bus_nm ();

  decode_queue #(.DEPTH(DEPTH), .ENABLE_M(1), .ENABLE_F(0)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .bus(bus), .count(count));
  decode_queue #(.DEPTH(DEPTH), .ENABLE_M(0), .ENABLE_F(1)) dut_nm (
    .clk(clk), .rstn(rstn), .flush(flush), .bus(bus_nm), .count(count_nm));

  assign bus_nm.in_valid  = bus.in_valid;
  assign bus_nm.in_instr  = bus.in_instr;
  assign bus_nm.in_pc     = bus.in_pc;
  assign bus_nm.out_ready = bus.out_ready;

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [2:0]  cls;
    logic [2:0]  f3;
    logic        alt;
    logic        muldiv;
    logic        link;
    logic        illegal;
  } dec_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } item_t;

  dec_t obs, obs_nm;
  assign obs = {bus.out_pc, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_imm, bus.out_class,
                bus.out_funct3, bus.out_alt, bus.out_muldiv, bus.out_link, bus.out_illegal};
  assign obs_nm = {bus_nm.out_pc, bus_nm.out_rd, bus_nm.out_rs1, bus_nm.out_rs2, bus_nm.out_imm,
                   bus_nm.out_class, bus_nm.out_funct3, bus_nm.out_alt, bus_nm.out_muldiv,
                   bus_nm.out_link, bus_nm.out_illegal};

  int checks = 0;
  int errors = 0;

  item_t m_q[$];
  logic  m_ov = 1'b0;
  item_t m_out = '0;

  function automatic dec_t ref_decode(input logic [31:0] i, input logic [31:0] pc,
                                      input bit em, input bit ef);
    dec_t d;
    byte fmt;
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = i[31:25];
    f3 = i[14:12];
    d = '0;
    d.pc = pc;
    d.f3 = f3;
    fmt = "R";
    case (i[6:0])
      7'h33: begin
        d.alt = i[30];
        if (f7 == 7'h01) begin
          if (em) d.muldiv = 1'b1; else d.illegal = 1'b1;
        end else if (f7 == 7'h20) d.illegal = !(f3 == 3'd0 || f3 == 3'd5);
        else if (f7 != 7'h00) d.illegal = 1'b1;
      end
      7'h13: begin
        fmt = "I"; d.cls = 3'd1;
        if (f3 == 3'd1) d.illegal = (f7 != 7'h00);
        if (f3 == 3'd5) begin
          d.alt = i[30];
          d.illegal = !(f7 == 7'h00 || f7 == 7'h20);
        end
      end
      7'h03: begin fmt = "I"; d.cls = 3'd2; d.illegal = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7); end
      7'h23: begin fmt = "S"; d.cls = 3'd3; d.illegal = (f3 > 3'd2); end
      7'h63: begin fmt = "B"; d.cls = 3'd4; d.illegal = (f3 == 3'd2 || f3 == 3'd3); end
      7'h6F: begin fmt = "J"; d.cls = 3'd5; end
      7'h67: begin fmt = "I"; d.cls = 3'd5; d.link = 1'b1; end
      7'h37: begin fmt = "U"; d.cls = 3'd6; end
      7'h17: begin fmt = "U"; d.cls = 3'd6; d.link = 1'b1; end
      7'h0F, 7'h73: begin fmt = "I"; d.cls = 3'd7; end
      7'h07: begin fmt = "I"; d.cls = 3'd2; d.illegal = !ef; end
      7'h27: begin fmt = "S"; d.cls = 3'd3; d.illegal = !ef; end
      7'h53: begin fmt = "R"; d.cls = 3'd0; d.illegal = !ef; end
      default: d.illegal = 1'b1;
    endcase
    if (fmt == "R" || fmt == "I" || fmt == "U" || fmt == "J") d.rd = i[11:7];
    if (fmt == "R" || fmt == "I" || fmt == "S" || fmt == "B") d.rs1 = i[19:15];
    if (fmt == "R" || fmt == "S" || fmt == "B") d.rs2 = i[24:20];
    case (fmt)
      "I": d.imm = 32'($signed(i[31:20]));
      "S": d.imm = 32'($signed({i[31:25], i[11:7]}));
      "B": d.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      "U": d.imm = {i[31:12], 12'h000};
      "J": d.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      default: d.imm = 32'h0;
    endcase
    if (d.illegal) d.rd = 5'd0;
    return d;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  op;
    case ($urandom_range(0, 13))
      0: op = 7'h33;  1: op = 7'h13;  2: op = 7'h03;  3: op = 7'h23;
      4: op = 7'h63;  5: op = 7'h6F;  6: op = 7'h67;  7: op = 7'h37;
      8: op = 7'h17;  9: op = 7'h0F;  10: op = 7'h73; 11: op = 7'h07;
      12: op = 7'h27; default: op = 7'h53;
    endcase
    r = $urandom;
    r[6:0] = op;
    if (op == 7'h33 || op == 7'h13) begin
      case ($urandom_range(0, 3))
        0: r[31:25] = 7'h00;
        1: r[31:25] = 7'h20;
        2: r[31:25] = 7'h01;
        default: ;
      endcase
    end
    return r;
  endfunction

  // One clock: drive inputs, advance the flow model by the handshake rules, settle.
  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic rdy, input logic fl, output logic acc);
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.in_pc     = pc;
    bus.out_ready = rdy;
    flush         = fl;
    acc = rstn && !fl && v && (m_q.size() < DEPTH);
    @(posedge clk);
    if (!rstn || fl) begin
      m_q.delete();
      m_ov = 1'b0;
      if (!rstn) m_out = '0;
    end else begin
      if (m_q.size() > 0 && (!m_ov || rdy)) begin
        m_out = m_q.pop_front();
        m_ov = 1'b1;
      end else if (rdy) begin
        m_ov = 1'b0;
      end
      if (acc) m_q.push_back('{instr: ins, pc: pc});
    end
    #1;
  endtask

  task automatic test_reset();
    logic acc;
    rstn = 1'b0;
    cyc(1'b1, 32'h00000013, 32'h0, 1'b0, 1'b0, acc);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
    checks++;
    if (count !== 3'd0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: count=%0d out_valid=%b required count=0 out_valid=0", count, bus.out_valid);
    end
    checks++;
    if (obs !== '0 || obs_nm !== '0) begin
      errors++;
      $display("FAIL reset_bundle: got %h / %h required all zero", obs, obs_nm);
    end
    rstn = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
    end
    $display("reset: count=%0d out_valid=%b in_ready=%b", count, bus.out_valid, bus.in_ready);
  endtask

  task automatic test_addi();
    logic acc;
    cyc(1'b1, 32'hFFD08293, 32'h100, 1'b0, 1'b0, acc);
    checks++;
    if (bus.out_valid !== 1'b0 || count !== 3'd1) begin
      errors++;
      $display("FAIL addi_latency1: out_valid=%b count=%0d required 0 and 1", bus.out_valid, count);
    end
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_class !== 3'd1 || bus.out_rd !== 5'd5 ||
        bus.out_rs1 !== 5'd1 || bus.out_rs2 !== 5'd0 || bus.out_imm !== 32'hFFFFFFFD ||
        bus.out_pc !== 32'h100 || bus.out_illegal !== 1'b0) begin
      errors++;
      $display("FAIL addi_bundle: v=%b cls=%0d rd=%0d rs1=%0d rs2=%0d imm=%h pc=%h required 1 1 5 1 0 fffffffd 00000100",
               bus.out_valid, bus.out_class, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_imm, bus.out_pc);
    end
    $display("addi: cls=%0d rd=%0d imm=%h pc=%h", bus.out_class, bus.out_rd, bus.out_imm, bus.out_pc);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
  endtask

  task automatic test_formats();
    logic acc;
    logic [31:0] t_instr [5] = '{32'hFE208CE3, 32'h001000EF, 32'h123453B7, 32'h00008067, 32'h0020A423};
    logic [2:0]  t_cls   [5] = '{3'd4, 3'd5, 3'd6, 3'd5, 3'd3};
    logic [4:0]  t_rd    [5] = '{5'd0, 5'd1, 5'd7, 5'd0, 5'd0};
    logic [4:0]  t_rs1   [5] = '{5'd1, 5'd0, 5'd0, 5'd1, 5'd1};
    logic [4:0]  t_rs2   [5] = '{5'd2, 5'd0, 5'd0, 5'd0, 5'd2};
    logic [31:0] t_imm   [5] = '{32'hFFFFFFF8, 32'h00000800, 32'h12345000, 32'h0, 32'h8};
    logic        t_link  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, t_instr[k], 32'h2000 + 32'(k * 4), 1'b1, 1'b0, acc);
      cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_class !== t_cls[k] || bus.out_rd !== t_rd[k] ||
          bus.out_rs1 !== t_rs1[k] || bus.out_rs2 !== t_rs2[k] || bus.out_imm !== t_imm[k] ||
          bus.out_link !== t_link[k] || bus.out_illegal !== 1'b0) begin
        errors++;
        $display("FAIL format_%0d: cls=%0d rd=%0d rs1=%0d rs2=%0d imm=%h link=%b ill=%b required %0d %0d %0d %0d %h %b 0",
                 k, bus.out_class, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_imm, bus.out_link,
                 bus.out_illegal, t_cls[k], t_rd[k], t_rs1[k], t_rs2[k], t_imm[k], t_link[k]);
      end
      $display("format %h: cls=%0d rd=%0d imm=%h link=%b", t_instr[k], bus.out_class, bus.out_rd, bus.out_imm, bus.out_link);
    end
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
  endtask

  task automatic test_muldiv();
    logic acc;
    logic [31:0] t_instr [3] = '{32'h022081B3, 32'h00000FFF, 32'h0040A087};
    logic        t_ill1  [3] = '{1'b0, 1'b1, 1'b1};
    logic [4:0]  t_rd1   [3] = '{5'd3, 5'd0, 5'd0};
    logic        t_ill2  [3] = '{1'b1, 1'b1, 1'b0};
    logic [4:0]  t_rd2   [3] = '{5'd0, 5'd0, 5'd1};
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, t_instr[k], 32'h3000 + 32'(k * 4), 1'b1, 1'b0, acc);
      cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
      checks++;
      if (bus.out_illegal !== t_ill1[k] || bus.out_rd !== t_rd1[k] ||
          (k == 0 && (bus.out_muldiv !== 1'b1 || bus.out_class !== 3'd0))) begin
        errors++;
        $display("FAIL muldiv_m1_%0d: ill=%b rd=%0d muldiv=%b required ill=%b rd=%0d",
                 k, bus.out_illegal, bus.out_rd, bus.out_muldiv, t_ill1[k], t_rd1[k]);
      end
      checks++;
      if (bus_nm.out_illegal !== t_ill2[k] || bus_nm.out_rd !== t_rd2[k]) begin
        errors++;
        $display("FAIL muldiv_m0_%0d: ill=%b rd=%0d required ill=%b rd=%0d",
                 k, bus_nm.out_illegal, bus_nm.out_rd, t_ill2[k], t_rd2[k]);
      end
      $display("illegal %h: M1 ill=%b rd=%0d  M0F1 ill=%b rd=%0d", t_instr[k],
               bus.out_illegal, bus.out_rd, bus_nm.out_illegal, bus_nm.out_rd);
    end
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
  endtask

  task automatic test_full();
    logic acc;
    dec_t e;
    logic [31:0] w [6];
    int k = 0;
    for (int j = 0; j < 6; j++) w[j] = rand_instr();
    for (int c = 0; c < 8; c++) begin
      cyc(k < 6, w[k < 6 ? k : 5], 32'h200 + 32'(4 * k), 1'b0, 1'b0, acc);
      if (acc) k++;
    end
    checks++;
    if (count !== 3'd4 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_pc !== 32'h200) begin
      errors++;
      $display("FAIL full_state: count=%0d in_ready=%b out_valid=%b pc=%h required 4 0 1 00000200",
               count, bus.in_ready, bus.out_valid, bus.out_pc);
    end
    cyc(1'b1, w[5], 32'h214, 1'b1, 1'b0, acc);
    checks++;
    if (count !== 3'd3 || bus.out_pc !== 32'h204) begin
      errors++;
      $display("FAIL full_pulse: count=%0d pc=%h required 3 00000204", count, bus.out_pc);
    end
    cyc(1'b1, w[5], 32'h214, 1'b0, 1'b0, acc);
    checks++;
    if (count !== 3'd4) begin
      errors++;
      $display("FAIL full_late_push: count=%0d required 4", count);
    end
    for (int c = 0; c < 7; c++) begin
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
      checks++;
      if (count !== 3'(m_q.size()) || bus.out_valid !== m_ov) begin
        errors++;
        $display("FAIL full_drain_flow: count=%0d ov=%b required %0d %b", count, bus.out_valid, m_q.size(), m_ov);
      end
      if (m_ov) begin
        e = ref_decode(m_out.instr, m_out.pc, 1'b1, 1'b0);
        checks++;
        if (e.illegal ? ({obs.pc, obs.rd, obs.illegal} !== {e.pc, e.rd, e.illegal}) : (obs !== e)) begin
          errors++;
          $display("FAIL full_drain_bundle: got %h required %h", obs, e);
        end
        $display("drain pc=%h ill=%b", bus.out_pc, bus.out_illegal);
      end
    end
  endtask

  task automatic test_stream();
    logic acc;
    dec_t e;
    int taken = 0;
    int sent = 0;
    for (int c = 0; c < 24; c++) begin
      if (bus.out_valid === 1'b1) taken++;
      cyc(sent < 16, rand_instr(), 32'h1000 + 32'(4 * sent), 1'b1, 1'b0, acc);
      if (acc) sent++;
      checks++;
      if (count > 3'd1 || count !== 3'(m_q.size()) || bus.out_valid !== m_ov) begin
        errors++;
        $display("FAIL stream_flow c%0d: count=%0d ov=%b required %0d %b", c, count, bus.out_valid, m_q.size(), m_ov);
      end
      if (m_ov) begin
        e = ref_decode(m_out.instr, m_out.pc, 1'b1, 1'b0);
        checks++;
        if (e.illegal ? ({obs.pc, obs.rd, obs.illegal} !== {e.pc, e.rd, e.illegal}) : (obs !== e)) begin
          errors++;
          $display("FAIL stream_bundle c%0d: got %h required %h", c, obs, e);
        end
        e = ref_decode(m_out.instr, m_out.pc, 1'b0, 1'b1);
        checks++;
        if (e.illegal ? ({obs_nm.pc, obs_nm.rd, obs_nm.illegal} !== {e.pc, e.rd, e.illegal}) : (obs_nm !== e)) begin
          errors++;
          $display("FAIL stream_bundle_m0f1 c%0d: got %h required %h", c, obs_nm, e);
        end
        $display("stream pc=%h instr=%h cls=%0d ill=%b", bus.out_pc, m_out.instr, bus.out_class, bus.out_illegal);
      end
    end
    checks++;
    if (taken != 16) begin
      errors++;
      $display("FAIL stream_count: bundles taken=%0d required 16", taken);
    end
  endtask

  task automatic test_flush();
    logic acc;
    for (int k = 0; k < 4; k++)
      cyc(1'b1, 32'h00100093 + 32'(k << 20), 32'h400 + 32'(4 * k), 1'b0, 1'b0, acc);
    checks++;
    if (count !== 3'd3 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_prefill: count=%0d ov=%b required 3 1", count, bus.out_valid);
    end
    cyc(1'b1, 32'h00500093, 32'h410, 1'b0, 1'b1, acc);
    checks++;
    if (count !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_state: count=%0d ov=%b in_ready=%b required 0 0 1", count, bus.out_valid, bus.in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
      checks++;
      if (bus.out_valid !== 1'b0 || count !== 3'd0) begin
        errors++;
        $display("FAIL flush_ghost c%0d: ov=%b count=%0d pc=%h required 0 0", c, bus.out_valid, count, bus.out_pc);
      end
    end
    cyc(1'b1, 32'h00700393, 32'h300, 1'b1, 1'b0, acc);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h300 || bus.out_rd !== 5'd7) begin
      errors++;
      $display("FAIL flush_resume: ov=%b pc=%h rd=%0d required 1 00000300 7", bus.out_valid, bus.out_pc, bus.out_rd);
    end
    $display("flush: resumed pc=%h rd=%0d", bus.out_pc, bus.out_rd);
    cyc(1'b1, 32'h00100093, 32'h304, 1'b0, 1'b0, acc);
    rstn = 1'b0;
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
    checks++;
    if (count !== 3'd0 || bus.out_valid !== 1'b0 || obs !== '0) begin
      errors++;
      $display("FAIL reset_over_flush: count=%0d ov=%b bundle=%h required 0 0 zero", count, bus.out_valid, obs);
    end
    rstn = 1'b1;
  endtask

  task automatic test_random();
    logic acc;
    dec_t e;
    for (int c = 0; c < 300; c++) begin
      cyc($urandom_range(0, 3) != 0, rand_instr(), $urandom & 32'hFFFFFFFC,
          $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0, acc);
      checks++;
      if (count !== 3'(m_q.size()) || bus.out_valid !== m_ov || bus.in_ready !== (m_q.size() < DEPTH)) begin
        errors++;
        $display("FAIL random_flow c%0d: count=%0d ov=%b ir=%b required %0d %b %b",
                 c, count, bus.out_valid, bus.in_ready, m_q.size(), m_ov, m_q.size() < DEPTH);
      end
      if (m_ov) begin
        e = ref_decode(m_out.instr, m_out.pc, 1'b1, 1'b0);
        checks++;
        if (e.illegal ? ({obs.pc, obs.rd, obs.illegal} !== {e.pc, e.rd, e.illegal}) : (obs !== e)) begin
          errors++;
          $display("FAIL random_bundle c%0d: got %h required %h", c, obs, e);
        end
        $display("random c%0d pc=%h cls=%0d ill=%b count=%0d", c, bus.out_pc, bus.out_class, bus.out_illegal, count);
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_instr  = 32'h0;
    bus.in_pc     = 32'h0;
    bus.out_ready = 1'b0;
    test_reset();
    test_addi();
    test_formats();
    test_muldiv();
    test_full();
    test_stream();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
